// File: rtl/inc_mod.sv
// Parametrised modulo-N up/down counter with enable prescaler, parallel load,
// wrap/saturate boundary mode and a registered carry/borrow pulse for cascading.
module inc_mod #(
    parameter int unsigned      WIDTH    = 16,
    parameter longint unsigned  N        = 8,
    parameter int               DIV      = 1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             at_zero
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    // Terminal count held one bit wider so N = 2^WIDTH needs no truncating compare.
    localparam logic [W1-1:0]    LAST_W1 = W1'(N - 64'd1);
    localparam logic [WIDTH-1:0] LAST    = LAST_W1[WIDTH-1:0];

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("inc_mod: WIDTH must be in 1..32");
    end
    if (N < 2 || N > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("inc_mod: N must be in 2..2^WIDTH");
    end
    if (DIV < 1) begin : g_bad_div
        $error("inc_mod: DIV must be at least 1");
    end

    logic             step_c;
    logic [WIDTH-1:0] count_nxt;
    logic             carry_nxt;

    // Prescaler: a step fires on every DIV-th enabled cycle; load and reset restart it.
    if (DIV > 1) begin : g_pre
        localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
        logic [PW-1:0] pre;

        always_ff @(posedge clock) begin
            if (reset || load) begin
                pre <= '0;
            end else if (enable) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
            end
        end

        assign step_c = enable && (pre == PRE_LAST);
    end else begin : g_no_pre
        assign step_c = enable;
    end

    // Next-state: load > step > hold; carry is only ever a one-edge pulse.
    always_comb begin
        count_nxt = count;
        carry_nxt = 1'b0;
        if (load) begin
            count_nxt = ({1'b0, load_value} > LAST_W1) ? LAST : load_value;
        end else if (step_c) begin
            if (up) begin
                if (count == LAST) begin
                    carry_nxt = 1'b1;
                    count_nxt = SATURATE ? LAST : '0;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    carry_nxt = 1'b1;
                    count_nxt = SATURATE ? '0 : LAST;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            carry   <= 1'b0;
            at_zero <= 1'b1;
        end else begin
            count   <= count_nxt;
            carry   <= carry_nxt;
            at_zero <= (count_nxt == '0);
        end
    end

endmodule

// File: tb/tb_inc_mod.sv
// Scoreboarded bench for inc_mod: four configurations share one stimulus stream,
// a behavioural model predicts each edge and the queue is drained after the edge.
module tb_inc_mod;

    localparam int NI = 4;
    localparam int unsigned     WS [NI] = '{16, 16, 16, 4};
    localparam longint unsigned NS [NI] = '{8, 5, 8, 16};
    localparam int              DS [NI] = '{1, 1, 3, 1};
    localparam bit              SS [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic [31:0] cnt;
        logic        cy;
        logic        zero;
    } obs_t;
    typedef obs_t [NI-1:0] obs4_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        up;
    logic        load;
    logic [15:0] lv;

    logic [15:0] c0, c1, c2;
    logic [3:0]  c3;
    logic        cy0, cy1, cy2, cy3;
    logic        z0, z1, z2, z3;

    int n_checks = 0;
    int n_err    = 0;

    obs4_t sb[$];

    longint unsigned m_cnt [NI];
    int              m_pre [NI];
    bit              m_cy  [NI];

    inc_mod #(.WIDTH(16), .N(8), .DIV(1), .SATURATE(1'b0)) u_def (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv), .count(c0), .carry(cy0), .at_zero(z0));
    inc_mod #(.WIDTH(16), .N(5), .DIV(1), .SATURATE(1'b1)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv), .count(c1), .carry(cy1), .at_zero(z1));
    inc_mod #(.WIDTH(16), .N(8), .DIV(3), .SATURATE(1'b0)) u_div (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv), .count(c2), .carry(cy2), .at_zero(z2));
    inc_mod #(.WIDTH(4), .N(16), .DIV(1), .SATURATE(1'b0)) u_full (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(lv[3:0]), .count(c3), .carry(cy3), .at_zero(z3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference for one edge of every configuration.
    task automatic model_edge(input bit r, e, u, l, input logic [15:0] v);
        obs4_t o;
        for (int k = 0; k < NI; k++) begin
            longint unsigned top;
            longint unsigned lvm;
            bit stp;
            top = NS[k] - 1;
            lvm = longint'(v) & ((64'd1 << WS[k]) - 1);
            stp = 1'b0;
            if (r) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_cy[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = (lvm > top) ? top : lvm;
                m_pre[k] = 0; m_cy[k] = 1'b0;
            end else begin
                m_cy[k] = 1'b0;
                if (e) begin
                    if (m_pre[k] == DS[k] - 1) begin
                        m_pre[k] = 0; stp = 1'b1;
                    end else begin
                        m_pre[k]++;
                    end
                end
                if (stp && u) begin
                    if (m_cnt[k] == top) begin
                        m_cy[k] = 1'b1;
                        if (!SS[k]) m_cnt[k] = 0;
                    end else m_cnt[k]++;
                end else if (stp) begin
                    if (m_cnt[k] == 0) begin
                        m_cy[k] = 1'b1;
                        if (!SS[k]) m_cnt[k] = top;
                    end else m_cnt[k]--;
                end
            end
            o[k] = {32'(m_cnt[k]), m_cy[k], m_cnt[k] == 0};
        end
        sb.push_back(o);
    endtask

    task automatic tick(input bit r, e, u, l, input logic [15:0] v);
        obs4_t ex;
        obs4_t got;
        reset = r; enable = e; up = u; load = l; lv = v;
        model_edge(r, e, u, l, v);
        @(posedge clock);
        #1;
        got[0] = {32'(c0), cy0, z0};
        got[1] = {32'(c1), cy1, z1};
        got[2] = {32'(c2), cy2, z2};
        got[3] = {32'(c3), cy3, z3};
        ex = sb.pop_front();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("count[%0d]", k),   64'(got[k].cnt),  64'(ex[k].cnt));
            check($sformatf("carry[%0d]", k),   64'(got[k].cy),   64'(ex[k].cy));
            check($sformatf("at_zero[%0d]", k), 64'(got[k].zero), 64'(ex[k].zero));
        end
    endtask

    initial begin
        int ncar;
        reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; lv = '0;

        tick(1, 0, 1, 0, 0);
        tick(1, 1, 1, 1, 16'd5);
        check("reset_count", 64'(c0), 64'd0);
        check("reset_at_zero", 64'(z0), 64'd1);

        // Default counting: 1..7,0,1,2.
        for (int i = 0; i < 10; i++) tick(0, 1, 1, 0, 0);
        check("def_after10", 64'(c0), 64'd2);

        // Down wrap from zero.
        tick(0, 1, 1, 1, 16'd0);
        check("load0_at_zero", 64'(z0), 64'd1);
        tick(0, 1, 0, 0, 0);
        check("down_wrap", 64'(c0), 64'd7);
        check("down_wrap_carry", 64'(cy0), 64'd1);
        tick(0, 1, 0, 0, 0);
        check("down_next_carry", 64'(cy0), 64'd0);

        // Saturation on the N=5 instance: 4,4,4 then hold at 0 going down.
        tick(0, 1, 1, 1, 16'd3);
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 0);
        check("sat_hold_hi", 64'(c1), 64'd4);
        check("sat_carry_hi", 64'(cy1), 64'd1);
        tick(0, 1, 0, 1, 16'd0);
        for (int i = 0; i < 2; i++) tick(0, 1, 0, 0, 0);
        check("sat_hold_lo", 64'(c1), 64'd0);
        check("sat_carry_lo", 64'(cy1), 64'd1);

        // Prescaler: 4 enabled, 2 idle, then two more enabled before the next step.
        tick(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 0);
        check("div_after4", 64'(c2), 64'd1);
        for (int i = 0; i < 2; i++) tick(0, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0);
        check("div_not_yet", 64'(c2), 64'd1);
        tick(0, 1, 1, 0, 0);
        check("div_step", 64'(c2), 64'd2);

        // Load clamp and reset-over-load.
        tick(0, 1, 1, 1, 16'd12);
        check("load_clamp", 64'(c0), 64'd7);
        check("load_noclamp_w4", 64'(c3), 64'd12);
        tick(1, 1, 1, 1, 16'd6);
        check("reset_beats_load", 64'(c0), 64'd0);

        // Full range on WIDTH=4, N=16: 17 up steps, exactly one carry.
        ncar = 0;
        for (int i = 0; i < 17; i++) begin
            tick(0, 1, 1, 0, 0);
            if (cy3 === 1'b1) ncar++;
        end
        check("full_final", 64'(c3), 64'd1);
        check("full_carry_once", 64'(ncar), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), $urandom_range(0, 9) == 0, 16'($urandom));
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/inc_mod.md
Name: inc_mod

Overview:
- Parametrised modulo up/down counter with enable; successor to the fixed 16-bit up-only modulo-n incrementer.
- Adds:
  - configurable width and modulus
  - direction control
  - synchronous parallel load
  - enable prescaler
  - wrap or saturate mode
  - registered carry/borrow pulse for cascading
- Used as a testbench counter and as the cosimulation reference for counter models.

Parameters:
- WIDTH, 16, width of count; 1..32.
- N, 8, modulus; count range is 0..N-1.
  - Legal range is 2..2^WIDTH.
  - Elaboration fails outside this range.
- DIV, 1, prescale factor; a step occurs every DIV-th enabled cycle.
  - Must be at least 1.
  - Elaboration fails if DIV < 1.
- SATURATE, 0, boundary mode.
  - 0: wrap at the boundary.
  - 1: hold at the boundary.

Ports:
- clock  in  1  rising-edge clock, only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance the prescaler; a step occurs when the prescaler expires.
- up  in  1  direction: 1 = increment, 0 = decrement. Sampled on step cycles.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- carry  out  1  registered one-cycle pulse on a boundary event.
- at_zero  out  1  registered; high when count == 0.

Behaviour:
- **Interface:** one clock, `clock`. Reset is `reset`: synchronous, active-high, sampled on the rising edge of `clock`. All state changes happen only on that edge.
- **Reset:**
  - count = 0, carry = 0, at_zero = 1.
  - Prescaler counter pre = 0.
  - Reset overrides load and enable in the same cycle.
  - Reset mid-sequence discards prescaler progress.
- **Priority per edge:** reset > load > step > hold.
- **Load:**
  - count = min(load_value, N-1).
  - pre = 0, carry = 0.
  - enable is ignored that cycle; no step occurs.
- **Prescaler:**
  - pre is a ceil(log2(DIV))-bit counter. It is absent when DIV = 1.
  - If enable = 1 and pre == DIV-1: pre = 0 and a step occurs.
  - If enable = 1 and pre < DIV-1: pre increments and no step occurs.
  - If enable = 0: pre holds.
  - DIV = 1 means every enabled cycle is a step.
- **Step, up = 1:**
  - count < N-1: count + 1.
  - count == N-1 and SATURATE = 0: count = 0, carry = 1.
  - count == N-1 and SATURATE = 1: count holds at N-1, carry = 1 (overflow indication).
- **Step, up = 0:**
  - count > 0: count - 1.
  - count == 0 and SATURATE = 0: count = N-1, carry = 1.
  - count == 0 and SATURATE = 1: count holds at 0, carry = 1.
- **carry:**
  - High for exactly the one cycle following the boundary step.
  - Cleared on every other edge, including hold and load edges.
  - Back-to-back boundary steps (e.g. saturated hold with enable high, DIV = 1) keep carry high continuously.
- **at_zero:** updated on the same edge as count; always equals (next count == 0).
- **Latency:** count and flags reflect a step one edge after the step condition is sampled.
- **Arithmetic:**
  - No intermediate exceeds WIDTH+1 bits.
  - N = 2^WIDTH uses natural wrap with no compare-induced truncation.
  - The N-1 constant is computed at WIDTH+1 bits.
- **Direction change:** up may change on any cycle; it takes effect only on step cycles and does not disturb pre.
- **Invariant:** count never leaves 0..N-1 after any reset or load.

Test Plan:
- Defaults (WIDTH=16, N=8, DIV=1, SATURATE=0): reset, enable=1, up=1 for 10 cycles.
  - count reads 1,2,...,7,0,1,2.
  - carry high only in the cycle count shows 0.
  - at_zero tracks count == 0.
- Down wrap (N=8): from count=0, up=0, enable=1.
  - Next count = 7 with carry = 1.
  - Then 6, with carry = 0.
- Saturate (N=5, SATURATE=1): load 3, up=1, enable held.
  - count = 4, then 4, 4.
  - carry = 0 then 1, 1.
  - Down from 0 holds at 0 with carry = 1.
- Prescaler (DIV=3): enable=1 continuously from reset.
  - count steps on enabled cycles 3, 6, 9.
  - Drop enable for 2 cycles after the 4th enabled cycle: the next step needs 2 further enabled cycles.
- Load/clamp (N=8): assert load=1, load_value=12 with enable=1.
  - count = 7, pre cleared.
  - Load 0: at_zero = 1.
  - load and reset in the same cycle: count = 0.
- Full range (WIDTH=4, N=16): 17 up steps from 0.
  - count 1..15, 0, 1.
  - carry exactly once.
  - No X/overflow on count.
